// File: rtl/minisrc_pkg.sv
// Shared encodings for the MiniSRC control unit: opcodes, FSM states,
// instruction classes and strobe bit positions.
package minisrc_pkg;

  localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6,  OP_ROR  = 5'd7,  OP_ROL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9,  OP_SHRA = 5'd10, OP_SHL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15, OP_DIV  = 5'd16, OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18, OP_BR   = 5'd19, OP_JR   = 5'd20;
  localparam logic [4:0] OP_JAL  = 5'd21, OP_IN   = 5'd22, OP_OUT  = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  // T-steps occupy 0..7 so the low three bits double as the step number.
  typedef enum logic [3:0] {
    ST_T0 = 4'd0, ST_T1 = 4'd1, ST_T2 = 4'd2, ST_T3 = 4'd3,
    ST_T4 = 4'd4, ST_T5 = 4'd5, ST_T6 = 4'd6, ST_T7 = 4'd7,
    ST_IDLE = 4'd8, ST_HALT = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    CLS_LD, CLS_LDI, CLS_ST, CLS_RALU, CLS_IMM, CLS_MULDIV, CLS_UNARY, CLS_BR,
    CLS_JR, CLS_JAL, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
  } cls_e;

  localparam int DS_PC = 0, DS_ZLO = 1, DS_ZHI = 2, DS_MDR = 3;
  localparam int DS_HI = 4, DS_LO = 5, DS_INPORT = 6, DS_C = 7;

  localparam int LE_MAR = 0, LE_MDR = 1, LE_PC = 2, LE_IR = 3, LE_Y = 4, LE_Z = 5;
  localparam int LE_HI = 6, LE_LO = 7, LE_CON = 8, LE_OUTPORT = 9, LE_RA = 10;

  localparam int RC_GRA = 0, RC_GRB = 1, RC_GRC = 2, RC_ROUT = 3, RC_RIN = 4, RC_BAOUT = 5;

  localparam int ALU_AND = 0, ALU_OR = 1, ALU_ADD = 2, ALU_SUB = 3, ALU_MUL = 4;
  localparam int ALU_DIV = 5, ALU_SHR = 6, ALU_SHRA = 7, ALU_SHL = 8, ALU_ROR = 9;
  localparam int ALU_ROL = 10, ALU_NEG = 11, ALU_NOT = 12;

  // Final T-step of each instruction class.
  function automatic logic [2:0] last_step(cls_e cls);
    case (cls)
      CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO: last_step = 3'd3;
      CLS_UNARY, CLS_JAL:                          last_step = 3'd4;
      CLS_RALU, CLS_IMM, CLS_LDI:                  last_step = 3'd5;
      CLS_MULDIV, CLS_BR:                          last_step = 3'd6;
      CLS_LD, CLS_ST:                              last_step = 3'd7;
      default:                                     last_step = 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/minisrc_control_unit_if.sv
// Control-unit <-> datapath bundle. master = control unit, slave = datapath.
interface minisrc_control_unit_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] IR;
  logic              CON_FF;
  logic              Mem_Ready;
  logic              Stop;
  logic [7:0]        Drive_Sel;
  logic [10:0]       Load_En;
  logic [5:0]        Reg_Ctl;
  logic [12:0]       ALU_Op;
  logic              IncPC;
  logic              Read;
  logic              Write;
  logic              Run;
  logic [3:0]        Step;

  modport master (
    input  IR, CON_FF, Mem_Ready, Stop,
    output Drive_Sel, Load_En, Reg_Ctl, ALU_Op, IncPC, Read, Write, Run, Step
  );
  modport slave (
    output IR, CON_FF, Mem_Ready, Stop,
    input  Drive_Sel, Load_En, Reg_Ctl, ALU_Op, IncPC, Read, Write, Run, Step
  );
endinterface

// File: rtl/minisrc_cu_decode.sv
// Opcode decoder: IR[31:27] -> instruction class and one-hot ALU operation.
module minisrc_cu_decode
  import minisrc_pkg::*;
(
  input  logic [4:0]  opcode,
  output cls_e        cls,
  output logic [12:0] alu_op
);
  always_comb begin
    cls    = CLS_NOP;
    alu_op = '0;
    case (opcode)
      OP_LD:   begin cls = CLS_LD;     alu_op[ALU_ADD]  = 1'b1; end
      OP_LDI:  begin cls = CLS_LDI;    alu_op[ALU_ADD]  = 1'b1; end
      OP_ST:   begin cls = CLS_ST;     alu_op[ALU_ADD]  = 1'b1; end
      OP_ADD:  begin cls = CLS_RALU;   alu_op[ALU_ADD]  = 1'b1; end
      OP_SUB:  begin cls = CLS_RALU;   alu_op[ALU_SUB]  = 1'b1; end
      OP_AND:  begin cls = CLS_RALU;   alu_op[ALU_AND]  = 1'b1; end
      OP_OR:   begin cls = CLS_RALU;   alu_op[ALU_OR]   = 1'b1; end
      OP_ROR:  begin cls = CLS_RALU;   alu_op[ALU_ROR]  = 1'b1; end
      OP_ROL:  begin cls = CLS_RALU;   alu_op[ALU_ROL]  = 1'b1; end
      OP_SHR:  begin cls = CLS_RALU;   alu_op[ALU_SHR]  = 1'b1; end
      OP_SHRA: begin cls = CLS_RALU;   alu_op[ALU_SHRA] = 1'b1; end
      OP_SHL:  begin cls = CLS_RALU;   alu_op[ALU_SHL]  = 1'b1; end
      OP_ADDI: begin cls = CLS_IMM;    alu_op[ALU_ADD]  = 1'b1; end
      OP_ANDI: begin cls = CLS_IMM;    alu_op[ALU_AND]  = 1'b1; end
      OP_ORI:  begin cls = CLS_IMM;    alu_op[ALU_OR]   = 1'b1; end
      OP_MUL:  begin cls = CLS_MULDIV; alu_op[ALU_MUL]  = 1'b1; end
      OP_DIV:  begin cls = CLS_MULDIV; alu_op[ALU_DIV]  = 1'b1; end
      OP_NEG:  begin cls = CLS_UNARY;  alu_op[ALU_NEG]  = 1'b1; end
      OP_NOT:  begin cls = CLS_UNARY;  alu_op[ALU_NOT]  = 1'b1; end
      OP_BR:   begin cls = CLS_BR;     alu_op[ALU_ADD]  = 1'b1; end
      OP_JR:   cls = CLS_JR;
      OP_JAL:  cls = CLS_JAL;
      OP_IN:   cls = CLS_IN;
      OP_OUT:  cls = CLS_OUT;
      OP_MFHI: cls = CLS_MFHI;
      OP_MFLO: cls = CLS_MFLO;
      OP_HALT: cls = CLS_HALT;
      default: cls = CLS_NOP;
    endcase
  end
endmodule

// File: rtl/minisrc_control_unit.sv
// Hardwired MiniSRC control sequencer (fetch, decode, execute T-steps).
// Define MINISRC_CU_MEMWAIT_EN to stall memory steps on Mem_Ready.
module minisrc_control_unit
  import minisrc_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int MULDIV_CYCLES = 1
) (
  input  logic                  Clock,
  input  logic                  Clear,
  minisrc_control_unit_if.master bus
);
  localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MULDIV_CYCLES - 1);

  state_e           state_reg;
  logic [CNT_W-1:0] md_cnt_reg;
  cls_e             cls;
  logic [12:0]      alu_op;
  logic [7:0]       drive;
  logic [10:0]      load;
  logic [5:0]       rctl;
  logic [12:0]      alu;
  logic             inc_pc, rd, wr, mem_ok, mem_hold, md_wait, at_last;

  minisrc_cu_decode u_decode (
    .opcode (bus.IR[DATA_W-1 -: 5]),
    .cls    (cls),
    .alu_op (alu_op)
  );

`ifdef MINISRC_CU_MEMWAIT_EN
  assign mem_ok = bus.Mem_Ready;
`else
  assign mem_ok = 1'b1;
`endif

  assign mem_hold = (rd | wr) & ~mem_ok;
  assign md_wait  = (state_reg == ST_T4) && (cls == CLS_MULDIV) && (md_cnt_reg != MD_LAST);
  assign at_last  = (state_reg[2:0] == last_step(cls));

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_reg  <= ST_IDLE;
      md_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (!bus.Stop) state_reg <= ST_T0;
        ST_HALT: state_reg <= ST_HALT;
        default: begin
          if (mem_hold) begin
            state_reg <= state_reg;
          end else if (md_wait) begin
            md_cnt_reg <= md_cnt_reg + 1'b1;
          end else begin
            md_cnt_reg <= '0;
            if (state_reg == ST_T2 && cls == CLS_HALT) state_reg <= ST_HALT;
            else if (at_last) state_reg <= bus.Stop ? ST_IDLE : ST_T0;
            else state_reg <= state_e'(state_reg + 4'd1);
          end
        end
      endcase
    end
  end

  // Moore strobe decode; only br T6 looks at CON_FF.
  always_comb begin
    drive = '0; load = '0; rctl = '0; alu = '0;
    inc_pc = 1'b0; rd = 1'b0; wr = 1'b0;
    case (state_reg)
      ST_T0: begin drive[DS_PC] = 1'b1; load[LE_MAR] = 1'b1; load[LE_Z] = 1'b1; inc_pc = 1'b1; end
      ST_T1: begin drive[DS_ZLO] = 1'b1; load[LE_PC] = 1'b1; load[LE_MDR] = 1'b1; rd = 1'b1; end
      ST_T2: begin drive[DS_MDR] = 1'b1; load[LE_IR] = 1'b1; end
      ST_T3: case (cls)
        CLS_RALU, CLS_IMM: begin rctl[RC_GRB] = 1'b1; rctl[RC_ROUT] = 1'b1; load[LE_Y] = 1'b1; end
        CLS_LD, CLS_LDI, CLS_ST: begin
          rctl[RC_GRB] = 1'b1; rctl[RC_BAOUT] = 1'b1; rctl[RC_ROUT] = 1'b1; load[LE_Y] = 1'b1;
        end
        CLS_UNARY:  begin rctl[RC_GRB] = 1'b1; rctl[RC_ROUT] = 1'b1; alu = alu_op; load[LE_Z] = 1'b1; end
        CLS_MULDIV: begin rctl[RC_GRA] = 1'b1; rctl[RC_ROUT] = 1'b1; load[LE_Y] = 1'b1; end
        CLS_BR:     begin rctl[RC_GRA] = 1'b1; rctl[RC_ROUT] = 1'b1; load[LE_CON] = 1'b1; end
        CLS_JR:     begin rctl[RC_GRA] = 1'b1; rctl[RC_ROUT] = 1'b1; load[LE_PC] = 1'b1; end
        CLS_JAL:    begin drive[DS_PC] = 1'b1; load[LE_RA] = 1'b1; end
        CLS_IN:     begin drive[DS_INPORT] = 1'b1; rctl[RC_GRA] = 1'b1; rctl[RC_RIN] = 1'b1; end
        CLS_OUT:    begin rctl[RC_GRA] = 1'b1; rctl[RC_ROUT] = 1'b1; load[LE_OUTPORT] = 1'b1; end
        CLS_MFHI:   begin drive[DS_HI] = 1'b1; rctl[RC_GRA] = 1'b1; rctl[RC_RIN] = 1'b1; end
        CLS_MFLO:   begin drive[DS_LO] = 1'b1; rctl[RC_GRA] = 1'b1; rctl[RC_RIN] = 1'b1; end
        default: ;
      endcase
      ST_T4: case (cls)
        CLS_RALU:   begin rctl[RC_GRC] = 1'b1; rctl[RC_ROUT] = 1'b1; alu = alu_op; load[LE_Z] = 1'b1; end
        CLS_MULDIV: begin rctl[RC_GRB] = 1'b1; rctl[RC_ROUT] = 1'b1; alu = alu_op; load[LE_Z] = 1'b1; end
        CLS_IMM, CLS_LD, CLS_LDI, CLS_ST: begin drive[DS_C] = 1'b1; alu = alu_op; load[LE_Z] = 1'b1; end
        CLS_UNARY:  begin drive[DS_ZLO] = 1'b1; rctl[RC_GRA] = 1'b1; rctl[RC_RIN] = 1'b1; end
        CLS_BR:     begin drive[DS_PC] = 1'b1; load[LE_Y] = 1'b1; end
        CLS_JAL:    begin rctl[RC_GRA] = 1'b1; rctl[RC_ROUT] = 1'b1; load[LE_PC] = 1'b1; end
        default: ;
      endcase
      ST_T5: case (cls)
        CLS_RALU, CLS_IMM, CLS_LDI: begin drive[DS_ZLO] = 1'b1; rctl[RC_GRA] = 1'b1; rctl[RC_RIN] = 1'b1; end
        CLS_MULDIV:     begin drive[DS_ZLO] = 1'b1; load[LE_LO] = 1'b1; end
        CLS_LD, CLS_ST: begin drive[DS_ZLO] = 1'b1; load[LE_MAR] = 1'b1; end
        CLS_BR:         begin drive[DS_C] = 1'b1; alu = alu_op; load[LE_Z] = 1'b1; end
        default: ;
      endcase
      ST_T6: case (cls)
        CLS_MULDIV: begin drive[DS_ZHI] = 1'b1; load[LE_HI] = 1'b1; end
        CLS_LD:     begin rd = 1'b1; load[LE_MDR] = 1'b1; end
        CLS_ST:     begin rctl[RC_GRA] = 1'b1; rctl[RC_ROUT] = 1'b1; load[LE_MDR] = 1'b1; end
        CLS_BR:     begin drive[DS_ZLO] = 1'b1; load[LE_PC] = bus.CON_FF; end
        default: ;
      endcase
      ST_T7: case (cls)
        CLS_LD: begin drive[DS_MDR] = 1'b1; rctl[RC_GRA] = 1'b1; rctl[RC_RIN] = 1'b1; end
        CLS_ST: wr = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end

  assign bus.Drive_Sel = drive;
  assign bus.Load_En   = load;
  assign bus.Reg_Ctl   = rctl;
  assign bus.ALU_Op    = alu;
  assign bus.IncPC     = inc_pc;
  assign bus.Read      = rd;
  assign bus.Write     = wr;
  assign bus.Run       = ~state_reg[3];
  assign bus.Step      = state_reg[3] ? 4'd0 : {1'b0, state_reg[2:0]};
endmodule

// File: tb/tb_minisrc_control_unit.sv
// Self-checking bench for minisrc_control_unit: directed test-plan sequences,
// a latency table and randomized instructions against a micro-step model.
module tb_minisrc_control_unit;
  localparam int MD = 4;
`ifdef MINISRC_CU_MEMWAIT_EN
  localparam bit MEMWAIT = 1'b1;
`else
  localparam bit MEMWAIT = 1'b0;
`endif

  localparam logic [7:0]  D_PC = 8'h01, D_ZLO = 8'h02, D_ZHI = 8'h04, D_MDR = 8'h08;
  localparam logic [7:0]  D_HI = 8'h10, D_LO = 8'h20, D_IN = 8'h40, D_C = 8'h80;
  localparam logic [10:0] L_MAR = 11'h001, L_MDR = 11'h002, L_PC = 11'h004, L_IR = 11'h008;
  localparam logic [10:0] L_Y = 11'h010, L_Z = 11'h020, L_HI = 11'h040, L_LO = 11'h080;
  localparam logic [10:0] L_CON = 11'h100, L_OUT = 11'h200, L_RA = 11'h400;
  localparam logic [5:0]  R_GRA = 6'h01, R_GRB = 6'h02, R_GRC = 6'h04, R_ROUT = 6'h08;
  localparam logic [5:0]  R_RIN = 6'h10, R_BA = 6'h20;

  typedef struct packed {
    logic [7:0]  ds;
    logic [10:0] le;
    logic [5:0]  rc;
    logic [12:0] alu;
    logic        inc, rd, wr, run;
    logic [3:0]  step;
  } vec_t;

  typedef struct {
    logic [31:0] ir;
    bit          con;
    int          lat;
  } lat_t;

  logic clk = 1'b0;
  logic clear = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;
  vec_t seq[$];
  lat_t tbl[18];

  minisrc_control_unit_if #(.DATA_W(32)) bus ();
  minisrc_control_unit #(.DATA_W(32), .MULDIV_CYCLES(MD)) dut (
    .Clock (clk),
    .Clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t sample();
    vec_t v;
    v.ds = bus.Drive_Sel; v.le = bus.Load_En; v.rc = bus.Reg_Ctl; v.alu = bus.ALU_Op;
    v.inc = bus.IncPC; v.rd = bus.Read; v.wr = bus.Write; v.run = bus.Run; v.step = bus.Step;
    return v;
  endfunction

  task automatic check(input vec_t exp, input string name);
    vec_t got;
    got = sample();
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got ds=%h le=%h rc=%h alu=%h inc/rd/wr/run=%b%b%b%b step=%0d, want ds=%h le=%h rc=%h alu=%h inc/rd/wr/run=%b%b%b%b step=%0d",
               name, got.ds, got.le, got.rc, got.alu, got.inc, got.rd, got.wr, got.run, got.step,
               exp.ds, exp.le, exp.rc, exp.alu, exp.inc, exp.rd, exp.wr, exp.run, exp.step);
    end
  endtask

  function automatic logic [12:0] alu_of(input int op);
    case (op)
      4:       return 13'h0008;
      5, 13:   return 13'h0001;
      6, 14:   return 13'h0002;
      7:       return 13'h0200;
      8:       return 13'h0400;
      9:       return 13'h0040;
      10:      return 13'h0080;
      11:      return 13'h0100;
      15:      return 13'h0010;
      16:      return 13'h0020;
      17:      return 13'h0800;
      18:      return 13'h1000;
      default: return 13'h0004;
    endcase
  endfunction

  function automatic void push(input int t, input logic [7:0] ds, input logic [10:0] le,
                               input logic [5:0] rc, input logic [12:0] alu,
                               input logic inc, input logic rd, input logic wr);
    vec_t v;
    v.ds = ds; v.le = le; v.rc = rc; v.alu = alu;
    v.inc = inc; v.rd = rd; v.wr = wr; v.run = 1'b1; v.step = 4'(t);
    seq.push_back(v);
  endfunction

  // Expected cycle-by-cycle strobes for one instruction, written from the micro-step lists.
  function automatic void build(input int op, input bit con);
    logic [12:0] a;
    a = alu_of(op);
    seq.delete();
    push(0, D_PC, L_MAR | L_Z, 0, 0, 1, 0, 0);
    push(1, D_ZLO, L_PC | L_MDR, 0, 0, 0, 1, 0);
    push(2, D_MDR, L_IR, 0, 0, 0, 0, 0);
    case (op) inside
      [3:11]: begin
        push(3, 0, L_Y, R_GRB | R_ROUT, 0, 0, 0, 0);
        push(4, 0, L_Z, R_GRC | R_ROUT, a, 0, 0, 0);
        push(5, D_ZLO, 0, R_GRA | R_RIN, 0, 0, 0, 0);
      end
      [12:14]: begin
        push(3, 0, L_Y, R_GRB | R_ROUT, 0, 0, 0, 0);
        push(4, D_C, L_Z, 0, a, 0, 0, 0);
        push(5, D_ZLO, 0, R_GRA | R_RIN, 0, 0, 0, 0);
      end
      15, 16: begin
        push(3, 0, L_Y, R_GRA | R_ROUT, 0, 0, 0, 0);
        for (int k = 0; k < MD; k++) push(4, 0, L_Z, R_GRB | R_ROUT, a, 0, 0, 0);
        push(5, D_ZLO, L_LO, 0, 0, 0, 0, 0);
        push(6, D_ZHI, L_HI, 0, 0, 0, 0, 0);
      end
      17, 18: begin
        push(3, 0, L_Z, R_GRB | R_ROUT, a, 0, 0, 0);
        push(4, D_ZLO, 0, R_GRA | R_RIN, 0, 0, 0, 0);
      end
      0, 1, 2: begin
        push(3, 0, L_Y, R_GRB | R_BA | R_ROUT, 0, 0, 0, 0);
        push(4, D_C, L_Z, 0, 13'h0004, 0, 0, 0);
        if (op == 1) push(5, D_ZLO, 0, R_GRA | R_RIN, 0, 0, 0, 0);
        else         push(5, D_ZLO, L_MAR, 0, 0, 0, 0, 0);
        if (op == 0) begin
          push(6, 0, L_MDR, 0, 0, 0, 1, 0);
          push(7, D_MDR, 0, R_GRA | R_RIN, 0, 0, 0, 0);
        end else if (op == 2) begin
          push(6, 0, L_MDR, R_GRA | R_ROUT, 0, 0, 0, 0);
          push(7, 0, 0, 0, 0, 0, 0, 1);
        end
      end
      19: begin
        push(3, 0, L_CON, R_GRA | R_ROUT, 0, 0, 0, 0);
        push(4, D_PC, L_Y, 0, 0, 0, 0, 0);
        push(5, D_C, L_Z, 0, 13'h0004, 0, 0, 0);
        push(6, D_ZLO, con ? L_PC : 11'h000, 0, 0, 0, 0, 0);
      end
      20: push(3, 0, L_PC, R_GRA | R_ROUT, 0, 0, 0, 0);
      21: begin
        push(3, D_PC, L_RA, 0, 0, 0, 0, 0);
        push(4, 0, L_PC, R_GRA | R_ROUT, 0, 0, 0, 0);
      end
      22: push(3, D_IN, 0, R_GRA | R_RIN, 0, 0, 0, 0);
      23: push(3, 0, L_OUT, R_GRA | R_ROUT, 0, 0, 0, 0);
      24: push(3, D_HI, 0, R_GRA | R_RIN, 0, 0, 0, 0);
      25: push(3, D_LO, 0, R_GRA | R_RIN, 0, 0, 0, 0);
      default: ;
    endcase
  endfunction

  // Leaves the DUT in IDLE with Stop=0, so the next edge enters T0.
  task automatic do_reset();
    @(negedge clk);
    clear = 1'b0;
    bus.Stop = 1'b0; bus.Mem_Ready = 1'b1; bus.CON_FF = 1'b0;
    #1 check('0, "reset");
    @(negedge clk);
    clear = 1'b1;
    #1 check('0, "idle_after_reset");
  endtask

  // rmode: 0 memory always ready, 1 random readiness, 2 not ready for the first 3 tries.
  task automatic exec(input logic [31:0] ir, input bit con, input bit stop, input int rmode);
    int  op, cyc, tries, k;
    bit  hold;
    op = int'(ir[31:27]);
    build(op, con);
    cyc = 0;
    for (int i = 0; i < seq.size(); i++) begin
      tries = 0;
      do begin
        @(negedge clk);
        bus.IR = ir; bus.CON_FF = con; bus.Stop = stop;
        case (rmode)
          0:       bus.Mem_Ready = 1'b1;
          1:       bus.Mem_Ready = ($urandom_range(0, 2) != 0) || (tries >= 4);
          default: bus.Mem_Ready = (tries >= 3);
        endcase
        #1 check(seq[i], $sformatf("op%0d_T%0d", op, seq[i].step));
        hold = MEMWAIT && (seq[i].rd || seq[i].wr) && !bus.Mem_Ready;
        tries++;
        cyc++;
      end while (hold);
    end
    if (op == 27) begin
      repeat (4) begin
        @(negedge clk);
        bus.Stop = 1'($urandom_range(0, 1));
        #1 check('0, "halt_hold");
      end
    end else if (stop) begin
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) begin
        @(negedge clk);
        bus.Stop = (j < k - 1);
        #1 check('0, "stop_idle");
      end
    end
    $display("instr ir=%h op=%0d con=%0d stop=%0d cycles=%0d", ir, op, con, stop, cyc);
    if (op == 27) do_reset();
  endtask

  // Entered with the DUT sampled in T0; counts cycles until T0 is seen again.
  task automatic measure(input logic [31:0] ir, input bit con, output int c);
    bus.IR = ir; bus.CON_FF = con; bus.Stop = 1'b0; bus.Mem_Ready = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      #1 c++;
    end while (!(bus.Run === 1'b1 && bus.Step === 4'd0) && c < 40);
  endtask

  initial begin
    int c;
    tbl[0]  = '{32'h00000000, 1'b0, 8};  // ld
    tbl[1]  = '{32'h08000000, 1'b0, 6};  // ldi
    tbl[2]  = '{32'h10000000, 1'b0, 8};  // st
    tbl[3]  = '{32'h18918000, 1'b0, 6};  // add
    tbl[4]  = '{32'h60000000, 1'b0, 6};  // addi
    tbl[5]  = '{32'h78000000, 1'b0, 6 + MD};  // mul
    tbl[6]  = '{32'h80000000, 1'b0, 6 + MD};  // div
    tbl[7]  = '{32'h88000000, 1'b0, 5};  // neg
    tbl[8]  = '{32'h98000000, 1'b0, 7};  // br not taken
    tbl[9]  = '{32'h98000000, 1'b1, 7};  // br taken
    tbl[10] = '{32'hA0000000, 1'b0, 4};  // jr
    tbl[11] = '{32'hA8000000, 1'b0, 5};  // jal
    tbl[12] = '{32'hB0000000, 1'b0, 4};  // in
    tbl[13] = '{32'hB8000000, 1'b0, 4};  // out
    tbl[14] = '{32'hC0000000, 1'b0, 4};  // mfhi
    tbl[15] = '{32'hC8000000, 1'b0, 4};  // mflo
    tbl[16] = '{32'hD0000000, 1'b0, 3};  // nop
    tbl[17] = '{32'hF8000000, 1'b0, 3};  // reserved opcode 31

    bus.IR = '0; bus.CON_FF = 1'b0; bus.Mem_Ready = 1'b1; bus.Stop = 1'b0;
    do_reset();

    exec(32'h00000000, 1'b0, 1'b0, 0);   // fetch + ld
    exec(32'h18918000, 1'b0, 1'b0, 0);   // add R1,R2,R3
    exec(32'h99000000, 1'b0, 1'b0, 0);   // brzr not taken
    exec(32'h99000000, 1'b1, 1'b0, 0);   // brzr taken
    exec(32'h00000000, 1'b0, 1'b0, 2);   // ld with Mem_Ready low 3 cycles
    exec(32'h10000000, 1'b0, 1'b0, 2);   // st with Mem_Ready low 3 cycles
    exec(32'h78000000, 1'b0, 1'b0, 0);   // mul
    exec(32'h18918000, 1'b0, 1'b1, 0);   // add with Stop held high
    exec(32'hD8000000, 1'b0, 1'b0, 0);   // halt, then reset

    // Clear mid-instruction (st at T5) must zero every strobe at once.
    bus.IR = 32'h10000000;
    repeat (6) @(negedge clk);
    #1 clear = 1'b0;
    #1 check('0, "abort_clear");
    do_reset();

    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      measure(tbl[i].ir, tbl[i].con, c);
      n_checks++;
      if (c != tbl[i].lat) begin
        n_fails++;
        $display("FAIL latency ir=%h con=%0d: got %0d cycles, want %0d", tbl[i].ir, tbl[i].con, c, tbl[i].lat);
      end
    end
    do_reset();

    for (int n = 0; n < 150; n++) begin
      logic [31:0] ir;
      ir = $urandom;
      exec(ir, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
